// File: rtl/fsm_enchimento_vedacao_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_enchimento_vedacao_pkg
// Description : Shared definitions for the fill/seal stage of the bottling
//               line: the 3-bit state encoding and the default timing and
//               magazine constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_enchimento_vedacao_pkg;

  // Seven operating states; encoding 3'd7 is unused and recovers to PARADO.
  typedef enum logic [2:0] {
    PARADO     = 3'd0,
    TRANSPORTE = 3'd1,
    ENCHENDO   = 3'd2,
    VEDACAO    = 3'd3,
    LIBERANDO  = 3'd4,
    SAIDA      = 3'd5,
    ERRO       = 3'd6
  } estado_t;

  localparam int T_ENCHER_MAX_PADRAO = 50;
  localparam int T_VEDAR_PADRAO      = 4;
  localparam int ROLHAS_MAX_PADRAO   = 20;
  localparam int W_ROLHAS_PADRAO     = 5;
  localparam int W_TIMER_PADRAO      = 8;

endpackage
`default_nettype wire

// File: rtl/contador_rolhas.sv
`default_nettype none
// ============================================================================
// Module      : contador_rolhas
// Description : Cork magazine counter. Loads full capacity on reset or on a
//               refill request, counts down one cork per sealed bottle and
//               flags an empty magazine. Refill beats decrement.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               repor      - refill request, reloads ROLHAS_MAX
//               decrementa - consume one cork
//               contagem   - corks left
//               vazio      - magazine empty (contagem == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module contador_rolhas #(
  parameter int ROLHAS_MAX = 20,
  parameter int W_ROLHAS   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                repor,
  input  logic                decrementa,
  output logic [W_ROLHAS-1:0] contagem,
  output logic                vazio
);

  always_ff @(posedge clk) begin
    if (rst || repor) begin
      contagem <= W_ROLHAS'(ROLHAS_MAX);
    end else if (decrementa && (contagem != '0)) begin
      // The zero guard is a safety net; the FSM never seals with no corks.
      contagem <= contagem - W_ROLHAS'(1);
    end
  end

  assign vazio = (contagem == '0);

endmodule
`default_nettype wire

// File: rtl/fsm_enchimento_vedacao.sv
`default_nettype none
// ============================================================================
// Module      : fsm_enchimento_vedacao
// Description : Fill-and-seal stage of the bottling line. Moves one bottle at
//               a time to the fill position, fills it (with timeout), caps it,
//               holds it until inspection is free and then releases it with a
//               one-cycle GARRAFA_VEDADA pulse. Tracks the cork magazine.
// Ports       : CLOCK, RESET           - clock, synchronous active-high reset
//               START                  - line enable (level)
//               SENSOR_GARRAFA         - bottle at fill/cap position
//               SENSOR_NIVEL           - fill level reached
//               EM_INSPECAO            - downstream inspection busy
//               REPOR_ROLHAS           - cork refill pulse
//               MOTOR_ESTEIRA, VALVULA, VEDANDO - actuators
//               GARRAFA_ENCHIMENTO     - bottle being filled or sealed
//               GARRAFA_VEDADA         - sealed bottle released (1 cycle)
//               ROLHAS_RESTANTES       - corks left
//               ALARME_ROLHAS          - magazine empty
//               ERRO_TIMEOUT           - fill timeout, latched until reset
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_enchimento_vedacao
  import fsm_enchimento_vedacao_pkg::*;
#(
  parameter int T_ENCHER_MAX = T_ENCHER_MAX_PADRAO,
  parameter int T_VEDAR      = T_VEDAR_PADRAO,
  parameter int ROLHAS_MAX   = ROLHAS_MAX_PADRAO,
  parameter int W_ROLHAS     = W_ROLHAS_PADRAO,
  parameter int W_TIMER      = W_TIMER_PADRAO
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                START,
  input  logic                SENSOR_GARRAFA,
  input  logic                SENSOR_NIVEL,
  input  logic                EM_INSPECAO,
  input  logic                REPOR_ROLHAS,
  output logic                MOTOR_ESTEIRA,
  output logic                VALVULA,
  output logic                VEDANDO,
  output logic                GARRAFA_ENCHIMENTO,
  output logic                GARRAFA_VEDADA,
  output logic [W_ROLHAS-1:0] ROLHAS_RESTANTES,
  output logic                ALARME_ROLHAS,
  output logic                ERRO_TIMEOUT
);

  estado_t            estado;
  logic [W_TIMER-1:0] timer;
  logic               vedada_reg;
  logic               decrementa;
  logic               sem_rolhas;

  // The last sealing cycle consumes one cork.
  assign decrementa = (estado == VEDACAO) && (timer == W_TIMER'(T_VEDAR - 1));

  contador_rolhas #(
    .ROLHAS_MAX (ROLHAS_MAX),
    .W_ROLHAS   (W_ROLHAS)
  ) u_contador_rolhas (
    .clk        (CLOCK),
    .rst        (RESET),
    .repor      (REPOR_ROLHAS),
    .decrementa (decrementa),
    .contagem   (ROLHAS_RESTANTES),
    .vazio      (sem_rolhas)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      estado     <= PARADO;
      timer      <= '0;
      vedada_reg <= 1'b0;
    end else begin
      // Release pulse lasts only the first SAIDA cycle.
      vedada_reg <= 1'b0;
      case (estado)
        PARADO: begin
          timer <= '0;
          if (START) estado <= TRANSPORTE;
        end
        TRANSPORTE: begin
          timer <= '0;
          if (SENSOR_GARRAFA && !sem_rolhas) begin
            estado <= ENCHENDO;
          end else if (!SENSOR_GARRAFA && !START) begin
            estado <= PARADO;
          end
          // Bottle present but no corks: stall here until a refill.
        end
        ENCHENDO: begin
          // Level wins over timeout when both happen in the same cycle.
          if (SENSOR_NIVEL) begin
            estado <= VEDACAO;
            timer  <= '0;
          end else if (timer == W_TIMER'(T_ENCHER_MAX - 1)) begin
            estado <= ERRO;
            timer  <= '0;
          end else begin
            timer <= timer + W_TIMER'(1);
          end
        end
        VEDACAO: begin
          if (timer == W_TIMER'(T_VEDAR - 1)) begin
            estado <= LIBERANDO;
            timer  <= '0;
          end else begin
            timer <= timer + W_TIMER'(1);
          end
        end
        LIBERANDO: begin
          timer <= '0;
          if (!EM_INSPECAO) begin
            estado     <= SAIDA;
            vedada_reg <= 1'b1;
          end
        end
        SAIDA: begin
          timer <= '0;
          if (!SENSOR_GARRAFA) estado <= START ? TRANSPORTE : PARADO;
        end
        ERRO: begin
          timer <= '0;
        end
        default: begin
          estado <= PARADO;
          timer  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    MOTOR_ESTEIRA      = 1'b0;
    VALVULA            = 1'b0;
    VEDANDO            = 1'b0;
    GARRAFA_ENCHIMENTO = 1'b0;
    ERRO_TIMEOUT       = 1'b0;
    case (estado)
      TRANSPORTE: MOTOR_ESTEIRA = !(SENSOR_GARRAFA && sem_rolhas);
      ENCHENDO: begin
        VALVULA            = 1'b1;
        GARRAFA_ENCHIMENTO = 1'b1;
      end
      VEDACAO: begin
        VEDANDO            = 1'b1;
        GARRAFA_ENCHIMENTO = 1'b1;
      end
      SAIDA:   MOTOR_ESTEIRA = 1'b1;
      ERRO:    ERRO_TIMEOUT  = 1'b1;
      default: ;
    endcase
  end

  assign GARRAFA_VEDADA = vedada_reg;
  assign ALARME_ROLHAS  = sem_rolhas;

endmodule
`default_nettype wire
